tmds_decoder: RTL and testbench

// - Receive-side counterpart of tmds_encoder: takes one 10-bit TMDS channel word per pixel clock from a

---
 rtl/tmds_decoder.sv | 195 +++++++++++++++++++
 tb/tb_tmds_decoder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_decoder.sv
// TMDS receive channel: finds the 10-bit word boundary from control-token runs, then decodes to 8b/2b.
// Optional build macro TMDS_DECODER_LOSSCNT_EN adds a saturating lock-loss counter port.
module tmds_decoder #(
   parameter int unsigned TOKEN_RUN      = 8,
   parameter int unsigned SEARCH_TIMEOUT = 16,
   parameter int unsigned LOCK_TIMEOUT   = 4096
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [9:0] tmds_in,
   output logic [7:0] data_out,
   output logic [1:0] control_out,
   output logic       ve_out,
   output logic       locked_out,
   output logic [3:0] offset_out
`ifdef TMDS_DECODER_LOSSCNT_EN
   ,
   output logic [7:0] lock_loss_count_out
`endif
);

   localparam int unsigned TmoMax = (LOCK_TIMEOUT > SEARCH_TIMEOUT) ? LOCK_TIMEOUT : SEARCH_TIMEOUT;
   localparam int unsigned RunW   = $clog2(TOKEN_RUN + 1);
   localparam int unsigned TmoW   = $clog2(TmoMax + 1);

   localparam logic [RunW-1:0] RunLimit    = RunW'(TOKEN_RUN);
   localparam logic [TmoW-1:0] SearchLimit = TmoW'(SEARCH_TIMEOUT);
   localparam logic [TmoW-1:0] LockLimit   = TmoW'(LOCK_TIMEOUT);
   localparam logic [TmoW-1:0] TmoSat      = TmoW'(TmoMax);
   localparam logic [3:0]      OffsetLast  = 4'd9;

   localparam logic [9:0] Tok00 = 10'b1101010100;
   localparam logic [9:0] Tok01 = 10'b0010101011;
   localparam logic [9:0] Tok10 = 10'b0101010100;
   localparam logic [9:0] Tok11 = 10'b1010101011;

   typedef enum logic [0:0] {StSearch, StLocked} state_e;

   state_e          state_q, state_d;
   logic [RunW-1:0] run_q, run_d, run_inc;
   logic [TmoW-1:0] tmo_q, tmo_d, tmo_inc;
   logic [3:0]      offset_q, offset_d;

   logic [9:0]  prev_q;
   logic [19:0] pair;
   logic [9:0]  window;
   logic        win_token;
   logic [1:0]  win_code;

   logic [9:0]  s1_word_q;
   logic        s1_token_q;
   logic [1:0]  s1_code_q;

   logic [7:0]  dec_d;
   logic [7:0]  dec_byte;

   logic [7:0]  data_q;
   logic [1:0]  ctrl_q;
   logic        ve_q;

   // Window slides over the previous word and the current one; offset 0 selects the previous word.
   assign pair   = {tmds_in, prev_q};
   assign window = pair[{1'b0, offset_q} +: 10];

   always_comb begin
      win_token = 1'b1;
      win_code  = 2'b00;
      unique case (window)
         Tok00:   win_code = 2'b00;
         Tok01:   win_code = 2'b01;
         Tok10:   win_code = 2'b10;
         Tok11:   win_code = 2'b11;
         default: win_token = 1'b0;
      endcase
   end

   // Bit 9 undoes the DC-balance inversion, bit 8 selects XOR vs XNOR chaining.
   assign dec_d    = s1_word_q[9] ? ~s1_word_q[7:0] : s1_word_q[7:0];
   assign dec_byte = {dec_d[7:1] ^ dec_d[6:0] ^ {7{~s1_word_q[8]}}, dec_d[0]};

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         prev_q     <= '0;
         s1_word_q  <= '0;
         s1_token_q <= 1'b0;
         s1_code_q  <= '0;
      end else begin
         prev_q     <= tmds_in;
         s1_word_q  <= window;
         s1_token_q <= win_token;
         s1_code_q  <= win_code;
      end
   end

   assign run_inc = (run_q == RunLimit) ? run_q : run_q + RunW'(1);
   assign tmo_inc = (tmo_q == TmoSat) ? tmo_q : tmo_q + TmoW'(1);

   always_comb begin
      state_d  = state_q;
      run_d    = run_q;
      tmo_d    = tmo_q;
      offset_d = offset_q;
      unique case (state_q)
         StSearch: begin
            if (s1_token_q) begin
               tmo_d = '0;
               run_d = run_inc;
               if (run_inc == RunLimit) begin
                  state_d = StLocked;
                  run_d   = '0;
               end
            end else begin
               run_d = '0;
               tmo_d = tmo_inc;
               if (tmo_inc == SearchLimit) begin
                  offset_d = (offset_q == OffsetLast) ? 4'd0 : offset_q + 4'd1;
                  tmo_d    = '0;
               end
            end
         end
         StLocked: begin
            run_d = '0;
            if (s1_token_q) begin
               tmo_d = '0;
            end else begin
               tmo_d = tmo_inc;
               if (tmo_inc == LockLimit) begin
                  state_d = StSearch;
                  tmo_d   = '0;
               end
            end
         end
         default: state_d = StSearch;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q  <= StSearch;
         run_q    <= '0;
         tmo_q    <= '0;
         offset_q <= '0;
      end else begin
         state_q  <= state_d;
         run_q    <= run_d;
         tmo_q    <= tmo_d;
         offset_q <= offset_d;
      end
   end

   // Gate on the next state so the locking token itself is presented with locked_out.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         data_q <= '0;
         ctrl_q <= '0;
         ve_q   <= 1'b0;
      end else if (state_d == StLocked) begin
         if (s1_token_q) begin
            ve_q   <= 1'b0;
            ctrl_q <= s1_code_q;
         end else begin
            ve_q   <= 1'b1;
            data_q <= dec_byte;
         end
      end else begin
         data_q <= '0;
         ctrl_q <= '0;
         ve_q   <= 1'b0;
      end
   end

   assign data_out    = data_q;
   assign control_out = ctrl_q;
   assign ve_out      = ve_q;
   assign locked_out  = (state_q == StLocked);
   assign offset_out  = offset_q;

`ifdef TMDS_DECODER_LOSSCNT_EN
   logic       loss_event;
   logic [7:0] loss_q;

   assign loss_event = (state_q == StLocked) && (state_d == StSearch);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         loss_q <= '0;
      end else if (loss_event && (loss_q != 8'hFF)) begin
         loss_q <= loss_q + 8'd1;
      end
   end

   assign lock_loss_count_out = loss_q;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Scoreboard bench for tmds_decoder: bit-stream stimulus, per-cycle reference model, byte tracker.
module tb_tmds_decoder;

   localparam int TOKEN_RUN      = 8;
   localparam int SEARCH_TIMEOUT = 16;
   localparam int LOCK_TIMEOUT   = 4096;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] tmds = '0;
   logic [7:0] data_out;
   logic [1:0] control_out;
   logic       ve_out;
   logic       locked_out;
   logic [3:0] offset_out;
`ifdef TMDS_DECODER_LOSSCNT_EN
   logic [7:0] loss_out;
`endif

   always #5 clk = ~clk;

   tmds_decoder dut (
      .clk_in      (clk),
      .rst_in      (rst),
      .tmds_in     (tmds),
      .data_out    (data_out),
      .control_out (control_out),
      .ve_out      (ve_out),
      .locked_out  (locked_out),
`ifdef TMDS_DECODER_LOSSCNT_EN
      .lock_loss_count_out (loss_out),
`endif
      .offset_out  (offset_out)
   );

   typedef struct {
      logic [7:0] data;
      logic [1:0] ctrl;
      logic       ve;
      logic       locked;
      logic [3:0] off;
      logic [7:0] loss;
   } out_t;

   out_t       exp_q[$];
   out_t       exp_next;
   bit         exp_valid = 1'b0;
   logic [7:0] byte_q[$];
   bit         sbits[$];
   int         checks = 0;
   int         errors = 0;

   // Reference model state
   logic [9:0] m_prev, m_pend;
   int         m_off, m_run, m_tmo, m_loss;
   bit         m_locked, m_ve;
   logic [7:0] m_data;
   logic [1:0] m_ctrl;

   function automatic logic [9:0] tok_word(input int code);
      case (code)
         0:       return 10'b1101010100;
         1:       return 10'b0010101011;
         2:       return 10'b0101010100;
         default: return 10'b1010101011;
      endcase
   endfunction

   function automatic int token_code(input logic [9:0] w);
      for (int c = 0; c < 4; c++) if (w == tok_word(c)) return c;
      return -1;
   endfunction

   // Ten consecutive received bits starting 'off' bits into the previous word.
   function automatic logic [9:0] window(input logic [9:0] cur, input logic [9:0] prv, input int off);
      logic [19:0] s;
      logic [9:0]  r;
      s = {cur, prv};
      for (int j = 0; j < 10; j++) r[j] = s[off+j];
      return r;
   endfunction

   function automatic logic [7:0] decode(input logic [9:0] w);
      logic [7:0] d, o;
      d = w[9] ? ~w[7:0] : w[7:0];
      o[0] = d[0];
      for (int i = 1; i < 8; i++) o[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      return o;
   endfunction

   // Transmit-side encoding; the inversion choice is free since the receiver undoes either.
   function automatic logic [9:0] enc(input logic [7:0] b, input bit inv);
      logic [7:0] qm;
      bit         use_xnor;
      int         ones;
      ones     = $countones(b);
      use_xnor = (ones > 4) || (ones == 4 && !b[0]);
      qm[0]    = b[0];
      for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ b[i]) : (qm[i-1] ^ b[i]);
      return {inv, ~use_xnor, inv ? ~qm : qm};
   endfunction

   task automatic model_step(input logic [9:0] t, input bit r);
      logic [9:0] w;
      int         c;
      if (r) begin
         m_prev = '0; m_pend = '0; m_off = 0; m_run = 0; m_tmo = 0; m_loss = 0;
         m_locked = 1'b0; m_ve = 1'b0; m_data = '0; m_ctrl = '0;
      end else begin
         w = window(t, m_prev, m_off);
         c = token_code(m_pend);
         if (!m_locked) begin
            if (c >= 0) begin
               m_tmo = 0;
               m_run++;
               if (m_run == TOKEN_RUN) begin
                  m_locked = 1'b1;
                  m_run    = 0;
               end
            end else begin
               m_run = 0;
               m_tmo++;
               if (m_tmo == SEARCH_TIMEOUT) begin
                  m_off = (m_off + 1) % 10;
                  m_tmo = 0;
               end
            end
         end else if (c >= 0) begin
            m_tmo = 0;
         end else begin
            m_tmo++;
            if (m_tmo == LOCK_TIMEOUT) begin
               m_locked = 1'b0;
               m_tmo    = 0;
               if (m_loss < 255) m_loss++;
            end
         end
         if (!m_locked) begin
            m_data = '0; m_ctrl = '0; m_ve = 1'b0;
         end else if (c >= 0) begin
            m_ve = 1'b0; m_ctrl = 2'(c);
         end else begin
            m_ve = 1'b1; m_data = decode(m_pend);
         end
         m_prev = t;
         m_pend = w;
      end
      exp_next.data   = m_data;
      exp_next.ctrl   = m_ctrl;
      exp_next.ve     = m_ve;
      exp_next.locked = m_locked;
      exp_next.off    = 4'(m_off);
      exp_next.loss   = 8'(m_loss);
      exp_valid       = 1'b1;
   endtask

   // One pixel clock: publish last cycle's prediction, drive inputs, predict the next cycle.
   task automatic cycle(input logic [9:0] t, input bit r);
      @(posedge clk);
      #1;
      if (exp_valid) exp_q.push_back(exp_next);
      rst  = r;
      tmds = t;
      model_step(t, r);
   endtask

   task automatic send(input logic [9:0] w);
      logic [9:0] t;
      for (int j = 0; j < 10; j++) sbits.push_back(w[j]);
      while (sbits.size() >= 10) begin
         for (int j = 0; j < 10; j++) t[j] = sbits.pop_front();
         cycle(t, 1'b0);
      end
   endtask

   task automatic send_tok(input int code, input int n);
      repeat (n) send(tok_word(code));
   endtask

   task automatic send_byte(input logic [7:0] b, input bit track);
      if (track) byte_q.push_back(b);
      send(enc(b, 1'($urandom_range(0, 1))));
   endtask

   task automatic reset_dut(input int n, input int rot);
      sbits.delete();
      repeat (n) cycle('0, 1'b1);
      repeat (rot) sbits.push_back(1'b0);
   endtask

   task automatic chk(input string name, input int act, input int want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, act, want);
      end
   endtask

   // Monitor: every cycle presents an output word, compared against the queued prediction.
   out_t       mon_e;
   bit         mon_bad;
   logic [7:0] mon_b;
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_bad = (data_out !== mon_e.data) || (control_out !== mon_e.ctrl) ||
                      (ve_out !== mon_e.ve) || (locked_out !== mon_e.locked) ||
                      (offset_out !== mon_e.off);
`ifdef TMDS_DECODER_LOSSCNT_EN
            mon_bad = mon_bad || (loss_out !== mon_e.loss);
`endif
            checks++;
            if (mon_bad) begin
               errors++;
               $display("FAIL outputs @%0t: got data=%h ctrl=%b ve=%b lock=%b off=%0d want data=%h ctrl=%b ve=%b lock=%b off=%0d loss=%0d",
                        $time, data_out, control_out, ve_out, locked_out, offset_out,
                        mon_e.data, mon_e.ctrl, mon_e.ve, mon_e.locked, mon_e.off, mon_e.loss);
            end
            if (ve_out === 1'b1 && byte_q.size() > 0) begin
               mon_b = byte_q.pop_front();
               checks++;
               if (data_out !== mon_b) begin
                  errors++;
                  $display("FAIL loopback_byte @%0t: got %h want %h", $time, data_out, mon_b);
               end
            end
         end
      end
   end

   initial begin
      // Aligned token 00 stream from reset
      reset_dut(3, 0);
      send_tok(0, 20);
      @(negedge clk);
      chk("lock_aligned", int'(locked_out), 1);
      chk("offset_aligned", int'(offset_out), 0);
      chk("ctrl_aligned", int'(control_out), 0);

      // Single A5 then random encoded bytes, all tracked end to end
      send_byte(8'hA5, 1'b1);
      repeat (40) send_byte(8'($urandom), 1'b1);
      send_tok(1, 4);

      // Full byte sweep then {vsync,hsync}={1,0}
      for (int b = 0; b < 256; b++) send_byte(8'(b), 1'b1);
      send_tok(2, 6);
      @(negedge clk);
      chk("ctrl_after_sweep", int'(control_out), 2);
      chk("ve_after_sweep", int'(ve_out), 0);
      chk("bytes_drained", byte_q.size(), 0);

      // Lock loss after LOCK_TIMEOUT data words
      repeat (LOCK_TIMEOUT + 4) send_byte(8'($urandom), 1'b0);
      @(negedge clk);
      chk("lock_lost", int'(locked_out), 0);
`ifdef TMDS_DECODER_LOSSCNT_EN
      chk("loss_count", int'(loss_out), 1);
`endif

      // One short of the timeout, then a token keeps lock
      reset_dut(2, 0);
      send_tok(3, 12);
      repeat (LOCK_TIMEOUT - 1) send_byte(8'($urandom), 1'b0);
      send_tok(3, 1);
      repeat (20) send_byte(8'($urandom), 1'b0);
      @(negedge clk);
      chk("lock_kept", int'(locked_out), 1);

      // Rotated stream locks at offset 5, then a reset pulse
      reset_dut(2, 5);
      send_tok(0, 120);
      @(negedge clk);
      chk("lock_rot5", int'(locked_out), 1);
      chk("offset_rot5", int'(offset_out), 5);
      repeat (100) begin
         if ($urandom_range(0, 3) == 0) send_tok(int'($urandom_range(0, 3)), 1);
         else send_byte(8'($urandom), 1'b0);
      end
      cycle(10'h155, 1'b1);
      send_byte(8'h3C, 1'b0);
      @(negedge clk);
      chk("rst_locked", int'(locked_out), 0);
      chk("rst_offset", int'(offset_out), 0);
      chk("rst_data", int'(data_out), 0);
      chk("rst_ve", int'(ve_out), 0);

      // Random bursts at a random rotation
      reset_dut(2, int'($urandom_range(0, 9)));
      repeat (60) begin
         if ($urandom_range(0, 1) == 0) send_tok(int'($urandom_range(0, 3)), int'($urandom_range(6, 30)));
         else repeat ($urandom_range(5, 40)) send_byte(8'($urandom), 1'b0);
      end

      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
